gate_check_seq: RTL and testbench
=================================

Name: gate_check_seq

Overview:
Sequencer that drives a 2-input gate under test through its full truth table and checks each output against the expected value for a selected gate type. It counts mismatches, records which vectors failed, and flags non-binary (X/Z) outputs. It sits beside any 2-input gate module in the library (inputs a, b; output c) as a self-checking harness controller, so a bench only has to pulse start and read the result.

Parameters:
SETTLE, 2, cycles each input vector is held before c is sampled (legal range 1..15)

Ports:
clk      input   1  clock; all state updates on rising edge
rst_n    input   1  asynchronous active-low reset
start    input   1  begin a check run; accepted only in IDLE
op       input   3  gate type: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR; 6-7 illegal
a        output  1  operand A to the gate under test
b        output  1  operand B to the gate under test
c        input   1  output of the gate under test
busy     output  1  high while a run is in progress
done     output  1  one-cycle pulse at the end of a run
pass     output  1  result of the last run; valid from done until the next start
err_cnt  output  3  number of mismatching vectors in the last run (0..4)
fail_vec output  4  bit i set if vector i mismatched; vector i drives {a,b} = i[1:0]
x_seen   output  1  c was X or Z at any sample point in the last run
op_err   output  1  last start carried an illegal op

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, x_seen=0, op_err=0; vector index and settle counter cleared.
- Reset asserted mid-run aborts the run immediately. No done pulse is produced, and results read as the reset values.
- States: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE:
  - On start=1 with legal op: latch op, clear err_cnt, fail_vec, x_seen, op_err and pass; vec=0; go to DRIVE.
  - On start=1 with op 6 or 7: set op_err=1, pass=0, clear the other results, go to FINISH. No vectors are driven.
  - start=0: remain in IDLE. a and b hold their last values.
- DRIVE:
  - a=vec[1], b=vec[0], registered.
  - Settle counter counts 0..SETTLE-1. On reaching SETTLE-1, go to SAMPLE.
  - Each vector is held for SETTLE cycles of DRIVE plus 1 SAMPLE cycle.
- SAMPLE:
  - Compute expected = f(op, a, b).
  - Mismatch if c differs from expected, using case inequality: X or Z on c counts as a mismatch.
  - If c is X or Z, set x_seen.
  - On mismatch: err_cnt += 1, fail_vec[vec] = 1.
  - If vec==3, go to FINISH; otherwise vec += 1, clear the settle counter, go to DRIVE.
- FINISH: done=1 for exactly one cycle. pass = (err_cnt==0) && !op_err, where err_cnt includes this run's final update. Go to IDLE.
- busy=1 in DRIVE, SAMPLE and FINISH; 0 in IDLE.
- Latency: start is sampled at edge E0.
  - Legal op: busy rises after E0 and lasts 4*(SETTLE+1)+1 cycles, with done in the final cycle. SETTLE=2 gives 13 cycles.
  - Illegal op: busy and done are high together for 1 cycle.
- start while busy is ignored and not queued.
- start held high continuously: a new run begins in the first IDLE cycle after FINISH.
- op changes mid-run have no effect; the latched copy is used.
- err_cnt saturates naturally at 4 (3-bit width); no wrap is possible.

Test Plan:
- Correct gate: NOR model on a,b,c, op=3, SETTLE=2, start for 1 cycle -> a,b step through 00,01,10,11; done after 13 busy cycles; pass=1, err_cnt=0, fail_vec=0000, x_seen=0.
- Wrong op: NOR model with op=0 (AND) -> expected 0001 vs actual 1000; mismatches on vectors 0 and 3; err_cnt=2, fail_vec=1001, pass=0.
- Non-binary output: c tied to 1'bx, op=3 -> err_cnt=4, fail_vec=1111, x_seen=1, pass=0. Repeat with c tied to 1'bz, same result.
- Illegal op: op=6 with start -> busy=1 and done=1 in the same single cycle, op_err=1, pass=0, a and b unchanged, err_cnt=0. A following legal run clears op_err.
- Reset mid-run: assert rst_n=0 during vector 2 DRIVE -> all outputs zero asynchronously (before the next edge); no done pulse. After release, a fresh run with op=3 passes.
- start ignored while busy: pulse start again at busy cycle 5 with op=0 -> the run completes against op=3 with one done pulse, then IDLE; no second run.

Source files
------------

// File: rtl/gate_check_if.sv
// Bundle between gate_check_seq and the bench/gate it exercises.
// master starts runs and returns c; slave is the sequencer.
interface gate_check_if;
  logic       start;
  logic [2:0] op;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_vec;
  logic       x_seen;
  logic       op_err;

  modport master (
    output start, op, c,
    input  a, b, busy, done, pass,
    input  err_cnt, fail_vec,
    input  x_seen, op_err
  );

  modport slave (
    input  start, op, c,
    output a, b, busy, done, pass,
    output err_cnt, fail_vec,
    output x_seen, op_err
  );
endinterface

// File: rtl/gate_check_seq.sv
// Walks a 2-input gate through its truth table and scores
// each output against the selected gate function.
module gate_check_seq #(
  parameter int SETTLE = 2
) (
  input logic         clk,
  input logic         rst_n,
  gate_check_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    FINISH
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [2:0] op_q;
  logic [1:0] vec;
  logic [3:0] cnt;
  logic       exp_c;
  logic       mism;
  logic       c_bad;
  logic [2:0] err_nxt;
  logic       op_ok;

  assign op_ok = (bus.op < 3'd6);

  always_comb begin
    exp_c = 1'b0;
    case (op_q)
      3'd0:    exp_c = bus.a & bus.b;
      3'd1:    exp_c = bus.a | bus.b;
      3'd2:    exp_c = ~(bus.a & bus.b);
      3'd3:    exp_c = ~(bus.a | bus.b);
      3'd4:    exp_c = bus.a ^ bus.b;
      3'd5:    exp_c = ~(bus.a ^ bus.b);
      default: exp_c = 1'b0;
    endcase
  end

  // Case compares so a floating or unknown c is scored as a miss.
  assign c_bad   = (bus.c !== 1'b0) && (bus.c !== 1'b1);
  assign mism    = (bus.c !== exp_c);
  assign err_nxt = bus.err_cnt + {2'b00, mism};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= 3'd0;
      vec          <= 2'd0;
      cnt          <= 4'd0;
      bus.a        <= 1'b0;
      bus.b        <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.pass     <= 1'b0;
      bus.err_cnt  <= 3'd0;
      bus.fail_vec <= 4'd0;
      bus.x_seen   <= 1'b0;
      bus.op_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy     <= 1'b1;
            bus.pass     <= 1'b0;
            bus.err_cnt  <= 3'd0;
            bus.fail_vec <= 4'd0;
            bus.x_seen   <= 1'b0;
            if (op_ok) begin
              op_q       <= bus.op;
              vec        <= 2'd0;
              cnt        <= 4'd0;
              bus.a      <= 1'b0;
              bus.b      <= 1'b0;
              bus.op_err <= 1'b0;
              state      <= DRIVE;
            end else begin
              bus.op_err <= 1'b1;
              bus.done   <= 1'b1;
              state      <= FINISH;
            end
          end
        end
        DRIVE: begin
          if (cnt == CNT_LAST) begin
            cnt   <= 4'd0;
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SAMPLE: begin
          bus.err_cnt <= err_nxt;
          if (mism) begin
            bus.fail_vec[vec] <= 1'b1;
          end
          if (c_bad) begin
            bus.x_seen <= 1'b1;
          end
          if (vec == 2'd3) begin
            bus.done <= 1'b1;
            bus.pass <= (err_nxt == 3'd0) && !bus.op_err;
            state    <= FINISH;
          end else begin
            vec   <= vec + 2'd1;
            bus.a <= vec[1] ^ (&vec[0]);
            bus.b <= ~vec[0];
            cnt   <= 4'd0;
            state <= DRIVE;
          end
        end
        FINISH: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_check_seq.sv
// Directed bench for gate_check_seq driving a NOR model,
// an unknown c, and a floating c through the sequencer.
module tb_gate_check_seq;

  logic       clk;
  logic       rst_n;
  logic [1:0] c_mode;
  int         errors;
  int         checks;

  gate_check_if bus ();

  gate_check_seq #(.SETTLE(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (c_mode)
      2'd1:    bus.c = 1'bx;
      2'd2:    bus.c = 1'bz;
      default: bus.c = ~(bus.a | bus.b);
    endcase
  end

  function automatic logic [13:0] outs();
    return {bus.a, bus.b, bus.busy, bus.done,
            bus.pass, bus.err_cnt, bus.fail_vec,
            bus.x_seen, bus.op_err};
  endfunction

  task automatic do_run(input logic [2:0] o,
                        output int cyc,
                        output int dones,
                        output logic [7:0] ab_seq);
    @(negedge clk);
    bus.op    = o;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc    = 0;
    dones  = 0;
    ab_seq = 8'd0;
    while (bus.busy && cyc < 100) begin
      cyc++;
      if (bus.done) dones++;
      if (cyc == 1 || cyc == 4 ||
          cyc == 7 || cyc == 10)
        ab_seq = {ab_seq[5:0], bus.a, bus.b};
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (outs() !== 14'd0) begin
      errors++;
      $display("FAIL reset_active got=%b want=0",
               outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 14'd0) begin
      errors++;
      $display("FAIL reset_idle got=%b want=0",
               outs());
    end
  endtask

  task automatic test_correct_gate();
    int cyc;
    int dones;
    logic [7:0] seq;
    c_mode = 2'd0;
    do_run(3'd3, cyc, dones, seq);
    checks++;
    if (cyc !== 13) begin
      errors++;
      $display("FAIL nor_busy_len got=%0d want=13", cyc);
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL nor_done got=%0d want=1", dones);
    end
    checks++;
    if (seq !== 8'b00_01_10_11) begin
      errors++;
      $display("FAIL nor_ab_seq got=%b want=00011011",
               seq);
    end
    checks++;
    if ({bus.pass, bus.err_cnt, bus.fail_vec,
         bus.x_seen} !== 9'b1_000_0000_0) begin
      errors++;
      $display("FAIL nor_result got=%b want=100000000",
               {bus.pass, bus.err_cnt, bus.fail_vec,
                bus.x_seen});
    end
  endtask

  task automatic test_wrong_op();
    int cyc;
    int dones;
    logic [7:0] seq;
    c_mode = 2'd0;
    do_run(3'd0, cyc, dones, seq);
    checks++;
    if (bus.err_cnt !== 3'd2) begin
      errors++;
      $display("FAIL and_err_cnt got=%0d want=2",
               bus.err_cnt);
    end
    checks++;
    if (bus.fail_vec !== 4'b1001) begin
      errors++;
      $display("FAIL and_fail_vec got=%b want=1001",
               bus.fail_vec);
    end
    checks++;
    if ({bus.pass, bus.x_seen} !== 2'b00) begin
      errors++;
      $display("FAIL and_pass_x got=%b want=00",
               {bus.pass, bus.x_seen});
    end
  endtask

  task automatic test_nonbinary(input logic [1:0] mode);
    int cyc;
    int dones;
    logic [7:0] seq;
    logic cv;
    logic nv;
    logic [2:0] e_err;
    logic [3:0] e_fail;
    logic e_x;
    c_mode = mode;
    #1;
    cv     = bus.c;
    e_err  = 3'd0;
    e_fail = 4'd0;
    e_x    = $isunknown(cv);
    for (int v = 0; v < 4; v++) begin
      nv = ~(v[1] | v[0]);
      if (cv !== nv) begin
        e_err++;
        e_fail[v] = 1'b1;
      end
    end
    do_run(3'd3, cyc, dones, seq);
    checks++;
    if (bus.err_cnt !== e_err) begin
      errors++;
      $display("FAIL nb%0d_err_cnt got=%0d want=%0d",
               mode, bus.err_cnt, e_err);
    end
    checks++;
    if (bus.fail_vec !== e_fail) begin
      errors++;
      $display("FAIL nb%0d_fail_vec got=%b want=%b",
               mode, bus.fail_vec, e_fail);
    end
    checks++;
    if ({bus.x_seen, bus.pass} !==
        {e_x, e_err == 3'd0}) begin
      errors++;
      $display("FAIL nb%0d_x_pass got=%b want=%b",
               mode, {bus.x_seen, bus.pass},
               {e_x, e_err == 3'd0});
    end
    c_mode = 2'd0;
  endtask

  task automatic test_illegal_op();
    int cyc;
    int dones;
    logic [7:0] seq;
    logic [1:0] ab0;
    c_mode = 2'd0;
    ab0 = {bus.a, bus.b};
    do_run(3'd6, cyc, dones, seq);
    checks++;
    if ({cyc, dones} !== {32'd1, 32'd1}) begin
      errors++;
      $display("FAIL ill_len got=%0d/%0d want=1/1",
               cyc, dones);
    end
    checks++;
    if ({bus.op_err, bus.pass, bus.err_cnt}
        !== 5'b1_0_000) begin
      errors++;
      $display("FAIL ill_flags got=%b want=10000",
               {bus.op_err, bus.pass, bus.err_cnt});
    end
    checks++;
    if ({bus.a, bus.b} !== ab0) begin
      errors++;
      $display("FAIL ill_ab got=%b want=%b",
               {bus.a, bus.b}, ab0);
    end
    do_run(3'd3, cyc, dones, seq);
    checks++;
    if ({bus.op_err, bus.pass} !== 2'b01) begin
      errors++;
      $display("FAIL ill_clear got=%b want=01",
               {bus.op_err, bus.pass});
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int idle_n = 0;
    int idle_at = 0;
    c_mode = 2'd0;
    @(negedge clk);
    bus.op    = 3'd3;
    bus.start = 1'b1;
    for (int i = 1; i <= 27; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (!bus.busy) begin
        idle_n++;
        idle_at = i;
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (dones !== 2) begin
      errors++;
      $display("FAIL b2b_dones got=%0d want=2", dones);
    end
    checks++;
    if ({idle_n, idle_at} !== {32'd1, 32'd14}) begin
      errors++;
      $display("FAIL b2b_gap got=%0d@%0d want=1@14",
               idle_n, idle_at);
    end
    checks++;
    if ({bus.busy, bus.pass} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_end got=%b want=01",
               {bus.busy, bus.pass});
    end
  endtask

  task automatic test_ignore_busy();
    int cyc = 0;
    int dones = 0;
    int extra = 0;
    c_mode = 2'd0;
    @(negedge clk);
    bus.op    = 3'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.busy && cyc < 100) begin
      cyc++;
      if (bus.done) dones++;
      bus.start = (cyc == 5);
      if (cyc == 5) bus.op = 3'd0;
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) extra++;
    end
    checks++;
    if ({cyc, dones} !== {32'd13, 32'd1}) begin
      errors++;
      $display("FAIL ign_run got=%0d/%0d want=13/1",
               cyc, dones);
    end
    checks++;
    if ({bus.pass, bus.err_cnt} !== 4'b1_000) begin
      errors++;
      $display("FAIL ign_result got=%b want=1000",
               {bus.pass, bus.err_cnt});
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ign_rerun got=%0d want=0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    int dones = 0;
    logic [7:0] seq;
    c_mode = 2'd0;
    @(negedge clk);
    bus.op    = 3'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if ({bus.busy, bus.a, bus.b} !== 3'b110) begin
      errors++;
      $display("FAIL mid_vec2 got=%b want=110",
               {bus.busy, bus.a, bus.b});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 14'd0) begin
      errors++;
      $display("FAIL mid_async got=%b want=0", outs());
    end
    dones = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL mid_done got=%0d want=0", dones);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 14'd0) begin
      errors++;
      $display("FAIL mid_release got=%b want=0",
               outs());
    end
    do_run(3'd3, cyc, dones, seq);
    checks++;
    if ({cyc, dones} !== {32'd13, 32'd1}) begin
      errors++;
      $display("FAIL mid_rerun got=%0d/%0d want=13/1",
               cyc, dones);
    end
    checks++;
    if ({bus.pass, bus.fail_vec} !== 5'b1_0000) begin
      errors++;
      $display("FAIL mid_pass got=%b want=10000",
               {bus.pass, bus.fail_vec});
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    c_mode    = 2'd0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    repeat (3) @(negedge clk);
    test_reset();
    test_correct_gate();
    test_wrong_op();
    test_nonbinary(2'd1);
    test_nonbinary(2'd2);
    test_illegal_op();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
